uart_fifo_buffers: RTL and testbench

Parametrised TX/RX buffering stage of the UART, sitting between the APB register file and the TSR/RSR shift logic. It provides a single holding register per direction when FIFOs are off, and DATA_W/DEPTH-parametrised FIFOs when they are on. RX entries carry error status. New over the previous generation: full-depth counts, overrun detection, character-timeout, error-in-FIFO flag and automatic flush on a fifoen toggle.

---
 rtl/uart_buf_pkg.sv | 30 +++
 rtl/uart_fifo_buffers_fifo.sv | 54 +++++
 rtl/uart_fifo_buffers.sv | 149 ++++++++++++++
 tb/tb_uart_fifo_buffers.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buf_pkg.sv
// Shared types and helpers for the UART TX/RX buffering stage.
package uart_buf_pkg;

    typedef enum logic [1:0] {
        TL_ONE       = 2'b00,
        TL_QUARTER   = 2'b01,
        TL_HALF      = 2'b10,
        TL_NEAR_FULL = 2'b11
    } rxfiftl_e;

    // RX status bit offsets above the data field: PE=DATA_W, FE=DATA_W+1, BI=DATA_W+2
    localparam int unsigned ST_PE = 0;
    localparam int unsigned ST_FE = 1;
    localparam int unsigned ST_BI = 2;
    localparam int unsigned ST_W  = 3;

    function automatic int unsigned trig_level(input logic [1:0] sel, input int unsigned depth);
        int unsigned lvl;
        lvl = 1;
        case (rxfiftl_e'(sel))
            TL_ONE:       lvl = 1;
            TL_QUARTER:   lvl = depth / 4;
            TL_HALF:      lvl = depth / 2;
            TL_NEAR_FULL: lvl = depth - 2;
            default:      lvl = 1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_fifo_buffers_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module fifo_sync_p #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // A read on empty is ignored; a write on full only lands if a read frees the slot.
    assign do_rd    = rd_en && !empty && !clear;
    assign do_wr    = wr_en && (!full || do_rd) && !clear;
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/uart_fifo_buffers.sv
// UART TX/RX buffering: holding registers or FIFOs, with RX status, overrun and timeout.
module uart_fifo_buffers
    import uart_buf_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1,
    parameter int unsigned TO_CHARS = 4
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 fifoen,
    input  logic                 txclr,
    input  logic                 rxclr,
    input  logic [1:0]           rxfiftl,
    input  logic                 thr_wr_en,
    input  logic [DATA_W-1:0]    pwdata,
    input  logic                 tsr_load,
    output logic [DATA_W-1:0]    tx_data,
    input  logic                 receive_done,
    input  logic [DATA_W-1:0]    rsr_data,
    input  logic                 parity_error,
    input  logic                 frame_error,
    input  logic                 uart_break,
    input  logic                 rbr_rd_en,
    output logic [DATA_W+2:0]    rbr,
    input  logic                 char_tick,
    input  logic                 lsr_rd,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 rx_full,
    output logic                 rx_empty,
    output logic [CNT_W-1:0]     tx_count,
    output logic [CNT_W-1:0]     rx_count,
    output logic                 rbrf,
    output logic                 rx_trigger,
    output logic                 rx_timeout,
    output logic                 overrun,
    output logic                 rx_fifo_err
);

    localparam int unsigned RW   = DATA_W + ST_W;
    localparam int unsigned TO_W = $clog2(TO_CHARS + 1);

    logic              fifoen_q, toggle, tx_clear, rx_clear;
    logic [DATA_W-1:0] tx_head, thr;
    logic [CNT_W-1:0]  tx_cnt_f, rx_cnt_f, err_cnt;
    logic              tx_full_f, tx_empty_f, rx_full_f, rx_empty_f;
    logic [RW-1:0]     rx_in, rx_head, rbr_q;
    logic              thr_full, rbrf_q;
    logic              rx_push, rx_pop, push_err, pop_err, ovr_evt;
    logic [TO_W-1:0]   to_cnt;

    // Any fifoen change flushes both directions exactly like txclr+rxclr.
    assign toggle   = fifoen ^ fifoen_q;
    assign tx_clear = txclr | toggle;
    assign rx_clear = rxclr | toggle;
    assign rx_in    = {uart_break, frame_error, parity_error, rsr_data};

    fifo_sync_p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(pclk), .rst(preset), .wr_en(fifoen & thr_wr_en), .rd_en(fifoen & tsr_load),
        .clear(tx_clear), .data_in(pwdata), .data_out(tx_head), .count(tx_cnt_f),
        .full(tx_full_f), .empty(tx_empty_f)
    );

    fifo_sync_p #(.DATA_W(RW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(pclk), .rst(preset), .wr_en(fifoen & receive_done), .rd_en(fifoen & rbr_rd_en),
        .clear(rx_clear), .data_in(rx_in), .data_out(rx_head), .count(rx_cnt_f),
        .full(rx_full_f), .empty(rx_empty_f)
    );

    // Mirror of the RX FIFO's accept decisions, for error/timeout/overrun tracking.
    assign rx_pop   = fifoen && rbr_rd_en && !rx_empty_f && !rx_clear;
    assign rx_push  = fifoen && receive_done && (!rx_full_f || rx_pop) && !rx_clear;
    assign push_err = rx_push && (|rx_in[DATA_W +: ST_W]);
    assign pop_err  = rx_pop && (|rx_head[DATA_W +: ST_W]);
    assign ovr_evt  = fifoen ? (receive_done && rx_full_f && !rx_pop && !rx_clear)
                             : (receive_done && rbrf_q && !rx_clear);

    // Holding registers for non-FIFO mode.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            thr      <= '0;
            thr_full <= 1'b0;
            rbr_q    <= '0;
            rbrf_q   <= 1'b0;
        end else begin
            if (tx_clear) begin
                thr_full <= 1'b0;
            end else if (!fifoen) begin
                if (thr_wr_en) begin
                    thr      <= pwdata;
                    thr_full <= 1'b1;
                end else if (tsr_load) begin
                    thr_full <= 1'b0;
                end
            end
            if (rx_clear) begin
                rbrf_q <= 1'b0;
            end else if (!fifoen) begin
                if (receive_done) begin
                    rbr_q  <= rx_in;
                    rbrf_q <= 1'b1;
                end else if (rbr_rd_en) begin
                    rbrf_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            fifoen_q <= 1'b0;
            overrun  <= 1'b0;
            err_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            fifoen_q <= fifoen;
            if (ovr_evt)     overrun <= 1'b1;
            else if (lsr_rd) overrun <= 1'b0;
            if (rx_clear) begin
                err_cnt <= '0;
            end else if (push_err && !pop_err) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end else if (pop_err && !push_err) begin
                err_cnt <= err_cnt - CNT_W'(1);
            end
            if (!fifoen || rx_clear || rx_empty_f || rx_push || rx_pop) begin
                to_cnt <= '0;
            end else if (char_tick && (to_cnt != TO_W'(TO_CHARS))) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign tx_data     = fifoen ? tx_head    : thr;
    assign tx_count    = fifoen ? tx_cnt_f   : CNT_W'(thr_full);
    assign tx_empty    = fifoen ? tx_empty_f : ~thr_full;
    assign tx_full     = fifoen ? tx_full_f  : thr_full;
    assign rbr         = fifoen ? rx_head    : rbr_q;
    assign rx_count    = fifoen ? rx_cnt_f   : CNT_W'(rbrf_q);
    assign rx_empty    = fifoen ? rx_empty_f : ~rbrf_q;
    assign rx_full     = fifoen ? rx_full_f  : rbrf_q;
    assign rbrf        = fifoen ? ~rx_empty_f : rbrf_q;
    assign rx_trigger  = fifoen && (32'(rx_cnt_f) >= trig_level(rxfiftl, DEPTH));
    assign rx_timeout  = (to_cnt == TO_W'(TO_CHARS));
    assign rx_fifo_err = (err_cnt != '0);

endmodule

// File: tb/tb_uart_fifo_buffers.sv
// Directed bench for uart_fifo_buffers: vector table plus multi-cycle corner sequences.
module tb_uart_fifo_buffers;

    logic        pclk = 1'b0;
    logic        preset, fifoen, txclr, rxclr;
    logic [1:0]  rxfiftl;
    logic        thr_wr_en, tsr_load, receive_done, rbr_rd_en, char_tick, lsr_rd;
    logic        parity_error, frame_error, uart_break;
    logic [7:0]  pwdata, rsr_data, tx_data;
    logic [10:0] rbr;
    logic        tx_full, tx_empty, rx_full, rx_empty, rbrf, rx_trigger, rx_timeout, overrun, rx_fifo_err;
    logic [4:0]  tx_count, rx_count;

    int n_checks = 0;
    int n_miss   = 0;

    always #5 pclk = ~pclk;

    uart_fifo_buffers dut (
        .pclk(pclk), .preset(preset), .fifoen(fifoen), .txclr(txclr), .rxclr(rxclr),
        .rxfiftl(rxfiftl), .thr_wr_en(thr_wr_en), .pwdata(pwdata), .tsr_load(tsr_load),
        .tx_data(tx_data), .receive_done(receive_done), .rsr_data(rsr_data),
        .parity_error(parity_error), .frame_error(frame_error), .uart_break(uart_break),
        .rbr_rd_en(rbr_rd_en), .rbr(rbr), .char_tick(char_tick), .lsr_rd(lsr_rd),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .tx_count(tx_count), .rx_count(rx_count), .rbrf(rbrf), .rx_trigger(rx_trigger),
        .rx_timeout(rx_timeout), .overrun(overrun), .rx_fifo_err(rx_fifo_err)
    );

    typedef struct {
        logic        wtx, ltsr, rdone, rrd, tick;
        logic [7:0]  d;
        logic [2:0]  st;
        logic [4:0]  txc, rxc;
        logic [7:0]  txd;
        logic [10:0] rbr;
        logic        to, err;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic wtx, ltsr, rdone, rrd, tick,
                                input logic [7:0] d, input logic [2:0] st,
                                input logic [4:0] txc, rxc, input logic [7:0] txd,
                                input logic [10:0] r, input logic to, err);
        vec_t v;
        v.wtx = wtx; v.ltsr = ltsr; v.rdone = rdone; v.rrd = rrd; v.tick = tick;
        v.d = d; v.st = st; v.txc = txc; v.rxc = rxc; v.txd = txd; v.rbr = r;
        v.to = to; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs already driven, sample 1ns after the edge, drop the pulses.
    task automatic cyc();
        @(posedge pclk);
        #1;
        thr_wr_en = 0; tsr_load = 0; receive_done = 0; rbr_rd_en = 0; char_tick = 0;
        lsr_rd = 0; txclr = 0; rxclr = 0;
        parity_error = 0; frame_error = 0; uart_break = 0;
    endtask

    task automatic rx_push(input logic [7:0] d, input logic [2:0] st);
        receive_done = 1; rsr_data = d;
        {uart_break, frame_error, parity_error} = st;
        cyc();
    endtask

    task automatic tx_push(input logic [7:0] d);
        thr_wr_en = 1; pwdata = d;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        preset = 1; fifoen = 1; rxfiftl = 2'b10; txclr = 0; rxclr = 0;
        thr_wr_en = 0; tsr_load = 0; receive_done = 0; rbr_rd_en = 0; char_tick = 0; lsr_rd = 0;
        parity_error = 0; frame_error = 0; uart_break = 0; pwdata = 0; rsr_data = 0;

        //           wtx ltsr rdn rrd tick d     st   txc rxc txd    rbr       to err
        tbl[0]  = mk(0, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00, 11'h000, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 8'h11, 3'd0, 1, 0, 8'h11, 11'h000, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 8'h22, 3'd0, 2, 0, 8'h11, 11'h000, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 8'h00, 3'd0, 1, 0, 8'h22, 11'h000, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 8'h33, 3'd0, 1, 0, 8'h33, 11'h000, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00, 11'h000, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00, 11'h000, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 8'h41, 3'd2, 0, 1, 8'h00, 11'h241, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 0, 8'h42, 3'd0, 0, 2, 8'h00, 11'h241, 0, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 8'h00, 3'd0, 0, 1, 8'h00, 11'h042, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 8'h00, 3'd0, 0, 1, 8'h00, 11'h042, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 8'h00, 3'd0, 0, 1, 8'h00, 11'h042, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 1, 8'h00, 3'd0, 0, 1, 8'h00, 11'h042, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 8'h00, 3'd0, 0, 1, 8'h00, 11'h042, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 8'h00, 3'd0, 0, 1, 8'h00, 11'h042, 1, 0);
        tbl[15] = mk(0, 0, 0, 1, 0, 8'h00, 3'd0, 0, 0, 8'h00, 11'h000, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 1, 8'h00, 3'd0, 0, 0, 8'h00, 11'h000, 0, 0);
        tbl[17] = mk(0, 0, 1, 1, 0, 8'h7E, 3'd5, 0, 1, 8'h00, 11'h57E, 0, 1);
        tbl[18] = mk(0, 0, 1, 1, 0, 8'h01, 3'd0, 0, 1, 8'h00, 11'h001, 0, 0);
        tbl[19] = mk(0, 0, 1, 1, 0, 8'h02, 3'd1, 0, 1, 8'h00, 11'h102, 0, 1);
        tbl[20] = mk(0, 0, 1, 1, 0, 8'h03, 3'd2, 0, 1, 8'h00, 11'h203, 0, 1);
        tbl[21] = mk(0, 0, 0, 1, 0, 8'h00, 3'd0, 0, 0, 8'h00, 11'h000, 0, 0);

        #12;
        chk("reset tx_count", 32'(tx_count), 0);
        chk("reset tx_empty", 32'(tx_empty), 1);
        chk("reset rx_empty", 32'(rx_empty), 1);
        chk("reset tx_full",  32'(tx_full), 0);
        chk("reset tx_data",  32'(tx_data), 0);
        chk("reset rbr",      32'(rbr), 0);
        chk("reset overrun",  32'(overrun), 0);
        chk("reset rbrf",     32'(rbrf), 0);
        @(negedge pclk);
        preset = 0;
        cyc();

        for (int i = 0; i < 22; i++) begin
            thr_wr_en = tbl[i].wtx; tsr_load = tbl[i].ltsr; receive_done = tbl[i].rdone;
            rbr_rd_en = tbl[i].rrd; char_tick = tbl[i].tick;
            pwdata = tbl[i].d; rsr_data = tbl[i].d;
            {uart_break, frame_error, parity_error} = tbl[i].st;
            cyc();
            chk($sformatf("v%0d tx_count", i),    32'(tx_count),    32'(tbl[i].txc));
            chk($sformatf("v%0d rx_count", i),    32'(rx_count),    32'(tbl[i].rxc));
            chk($sformatf("v%0d tx_data", i),     32'(tx_data),     32'(tbl[i].txd));
            chk($sformatf("v%0d rbr", i),         32'(rbr),         32'(tbl[i].rbr));
            chk($sformatf("v%0d rx_timeout", i),  32'(rx_timeout),  32'(tbl[i].to));
            chk($sformatf("v%0d rx_fifo_err", i), 32'(rx_fifo_err), 32'(tbl[i].err));
        end

        // Fill RX past full: 17th write is dropped and raises overrun.
        for (int i = 0; i < 17; i++) rx_push(8'(i), 3'd0);
        chk("ovr rx_count", 32'(rx_count), 16);
        chk("ovr rx_full",  32'(rx_full), 1);
        chk("ovr overrun",  32'(overrun), 1);
        chk("ovr rbrf",     32'(rbrf), 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr rd%0d", i), 32'(rbr), i);
            rbr_rd_en = 1;
            cyc();
        end
        chk("ovr drained", 32'(rx_empty), 1);
        rxclr = 1; cyc();
        chk("ovr survives rxclr", 32'(overrun), 1);
        lsr_rd = 1; cyc();
        chk("ovr lsr clear", 32'(overrun), 0);

        // Trigger level at DEPTH/2 = 8.
        for (int i = 0; i < 7; i++) rx_push(8'h60 + 8'(i), 3'd0);
        chk("trig at 7", 32'(rx_trigger), 0);
        rx_push(8'h67, 3'd0);
        chk("trig at 8", 32'(rx_trigger), 1);
        rxfiftl = 2'b11; #1;
        chk("trig lvl14", 32'(rx_trigger), 0);
        rxfiftl = 2'b01; #1;
        chk("trig lvl4", 32'(rx_trigger), 1);
        rxfiftl = 2'b10;
        rxclr = 1; cyc();
        chk("trig after clr", 32'(rx_trigger), 0);
        chk("rxclr count", 32'(rx_count), 0);

        // Leaving FIFO mode with data in both FIFOs flushes them.
        tx_push(8'hA1); tx_push(8'hA2);
        rx_push(8'hB1, 3'd2); rx_push(8'hB2, 3'd0); rx_push(8'hB3, 3'd0);
        chk("pre-tog txc", 32'(tx_count), 2);
        chk("pre-tog rxc", 32'(rx_count), 3);
        chk("pre-tog err", 32'(rx_fifo_err), 1);
        fifoen = 0; cyc();
        chk("tog0 txc", 32'(tx_count), 0);
        chk("tog0 rxc", 32'(rx_count), 0);
        chk("tog0 err", 32'(rx_fifo_err), 0);

        // Holding-register mode.
        rxfiftl = 2'b00;
        rx_push(8'h55, 3'd0);
        chk("nf rbr 55", 32'(rbr), 11'h055);
        chk("nf rbrf", 32'(rbrf), 1);
        chk("nf trig forced", 32'(rx_trigger), 0);
        chk("nf ovr none", 32'(overrun), 0);
        rx_push(8'hAA, 3'd0);
        chk("nf rbr AA", 32'(rbr), 11'h0AA);
        chk("nf overrun", 32'(overrun), 1);
        rbr_rd_en = 1; cyc();
        chk("nf rbrf clr", 32'(rbrf), 0);
        receive_done = 1; rsr_data = 8'h3C; rbr_rd_en = 1; lsr_rd = 1; cyc();
        chk("nf rd+rx rbrf", 32'(rbrf), 1);
        chk("nf lsr clr", 32'(overrun), 0);
        tx_push(8'h5A);
        chk("nf thr full", 32'(tx_full), 1);
        chk("nf txd 5A", 32'(tx_data), 8'h5A);
        tx_push(8'hA5);
        chk("nf txd A5", 32'(tx_data), 8'hA5);
        chk("nf txc", 32'(tx_count), 1);
        tsr_load = 1; cyc();
        chk("nf thr empty", 32'(tx_empty), 1);

        // Back to FIFO mode: both FIFO views come up empty.
        tx_push(8'h77);
        chk("nf2 txc", 32'(tx_count), 1);
        chk("nf2 rxc", 32'(rx_count), 1);
        fifoen = 1; cyc();
        chk("tog1 txc", 32'(tx_count), 0);
        chk("tog1 rxc", 32'(rx_count), 0);
        chk("tog1 txd", 32'(tx_data), 0);
        chk("tog1 rbr", 32'(rbr), 0);
        rxfiftl = 2'b10;

        // Asynchronous reset in the middle of TX traffic.
        for (int i = 0; i < 5; i++) tx_push(8'h30 + 8'(i));
        chk("mid txc", 32'(tx_count), 5);
        chk("mid txd", 32'(tx_data), 8'h30);
        @(negedge pclk);
        preset = 1; #1;
        chk("async txc",   32'(tx_count), 0);
        chk("async empty", 32'(tx_empty), 1);
        chk("async txd",   32'(tx_data), 0);
        @(negedge pclk);
        preset = 0;
        cyc();
        chk("post rst txc", 32'(tx_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
